sort_result_streamer: RTL and testbench

- Sits directly downstream of sort_32_u8.
- Captures each 32-element sorted frame on the sorter's one-cycle vld_out pulse.
- Streams the frame out one byte per handshake over a valid/ready interface, index 0 first.
- Two-deep ping-pong frame buffer: the sorter can deliver a new frame while the previous one drains; frames arriving with both buffers occupied are dropped and flagged.

---
 rtl/sort_result_streamer_pkg.sv | 15 +
 rtl/sort_result_streamer_if.sv | 26 ++
 rtl/sort_result_streamer_frame_buf.sv | 41 ++++
 rtl/sort_result_streamer.sv | 151 +++++++++++++++
 tb/tb_sort_result_streamer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sort_result_streamer_pkg.sv
// Shared constants and types for the sort result streaming path.
package sort_pkg;

    localparam int SORT_N     = 32;
    localparam int SORT_W     = 8;
    localparam int SORT_IDX_W = $clog2(SORT_N);

    typedef logic [SORT_W-1:0] elem_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_e;

endpackage

// File: rtl/sort_result_streamer_if.sv
// Byte-stream valid/ready interface carrying one frame element per handshake.
interface sort_result_streamer_if import sort_pkg::*; ();

    logic                  dout_valid;
    logic                  dout_ready;
    elem_t                 dout_data;
    logic [SORT_IDX_W-1:0] dout_idx;
    logic                  dout_last;

    modport master (
        output dout_valid,
        output dout_data,
        output dout_idx,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout_valid,
        input  dout_data,
        input  dout_idx,
        input  dout_last,
        output dout_ready
    );

endinterface

// File: rtl/sort_result_streamer_frame_buf.sv
// One frame register: captures a full sorted frame, tracks LOADED, reads one element by index.
module sort_frame_buf
    import sort_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     clr,
    input  logic [SORT_N*SORT_W-1:0] din,
    input  logic [SORT_IDX_W-1:0]    rd_idx,
    output logic                     loaded,
    output elem_t                    rd_data
);

    elem_t mem_r [SORT_N];
    logic  loaded_r;

    // Frame storage; contents only matter while the buffer is LOADED
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < SORT_N; i++) begin
                mem_r[i] <= din[i*SORT_W +: SORT_W];
            end
        end
    end

    // A load on the same edge as a clear wins: the freed buffer takes the new frame
    always_ff @(posedge clk) begin
        if (rst) begin
            loaded_r <= 1'b0;
        end else if (load) begin
            loaded_r <= 1'b1;
        end else if (clr) begin
            loaded_r <= 1'b0;
        end
    end

    assign loaded  = loaded_r;
    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/sort_result_streamer.sv
// Ping-pong buffered streamer for sorted frames; optional drop counter via SORT_STREAM_DROP_CNT_EN.
module sort_result_streamer
    import sort_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vld_in,
    input  logic [SORT_N*SORT_W-1:0] din,
    sort_result_streamer_if.master   dout,
    output logic                     full,
    output logic                     ovf
`ifdef SORT_STREAM_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    localparam logic [SORT_IDX_W-1:0] IDX_ZERO = {SORT_IDX_W{1'b0}};
    localparam logic [SORT_IDX_W-1:0] IDX_PEN  = SORT_IDX_W'(SORT_N - 2);

    stream_state_e         state_r;
    logic                  wr_sel_r;
    logic                  rd_sel_r;
    logic [SORT_IDX_W-1:0] idx_r;
    logic                  dout_valid_r;
    elem_t                 dout_data_r;
    logic                  dout_last_r;
    logic                  ovf_r;

    logic [1:0]            loaded_s;
    logic [1:0]            load_s;
    logic [1:0]            clr_s;
    elem_t                 rd_data_s [2];
    logic                  hs_s;
    logic                  last_hs_s;
    logic                  accept_s;
    logic                  drop_s;
    logic                  other_sel_s;
    logic                  rd_buf_s;
    logic [SORT_IDX_W-1:0] rd_idx_s;
    elem_t                 rd_word_s;

    for (genvar g = 0; g < 2; g++) begin : g_buf
        sort_frame_buf u_buf (
            .clk     (clk),
            .rst     (rst),
            .load    (load_s[g]),
            .clr     (clr_s[g]),
            .din     (din),
            .rd_idx  (rd_idx_s),
            .loaded  (loaded_s[g]),
            .rd_data (rd_data_s[g])
        );
    end

    // Handshake decode, capture/drop decision and next-element read address
    always_comb begin
        hs_s        = dout_valid_r && dout.dout_ready;
        last_hs_s   = hs_s && dout_last_r;
        accept_s    = vld_in && (!(loaded_s[0] && loaded_s[1]) || last_hs_s);
        drop_s      = vld_in && !accept_s;
        other_sel_s = ~rd_sel_r;
        rd_buf_s    = last_hs_s ? other_sel_s : rd_sel_r;
        if (hs_s && !dout_last_r) begin
            rd_idx_s = idx_r + SORT_IDX_W'(1);
        end else begin
            rd_idx_s = IDX_ZERO;
        end
        rd_word_s   = rd_data_s[rd_buf_s];
        load_s[0]   = accept_s && !wr_sel_r;
        load_s[1]   = accept_s && wr_sel_r;
        clr_s[0]    = last_hs_s && !rd_sel_r;
        clr_s[1]    = last_hs_s && rd_sel_r;
    end

    // Output FSM, buffer pointers and drop pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            wr_sel_r     <= 1'b0;
            rd_sel_r     <= 1'b0;
            idx_r        <= IDX_ZERO;
            dout_valid_r <= 1'b0;
            dout_data_r  <= {SORT_W{1'b0}};
            dout_last_r  <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            ovf_r <= drop_s;
            if (accept_s) begin
                wr_sel_r <= ~wr_sel_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (loaded_s[rd_sel_r]) begin
                        state_r      <= ST_STREAM;
                        dout_valid_r <= 1'b1;
                        idx_r        <= IDX_ZERO;
                        dout_data_r  <= rd_word_s;
                        dout_last_r  <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (last_hs_s) begin
                        rd_sel_r    <= other_sel_s;
                        idx_r       <= IDX_ZERO;
                        dout_last_r <= 1'b0;
                        // Back-to-back frames only when the other buffer already held data
                        if (loaded_s[other_sel_s]) begin
                            dout_data_r <= rd_word_s;
                        end else begin
                            state_r      <= ST_IDLE;
                            dout_valid_r <= 1'b0;
                            dout_data_r  <= {SORT_W{1'b0}};
                        end
                    end else if (hs_s) begin
                        idx_r       <= rd_idx_s;
                        dout_data_r <= rd_word_s;
                        dout_last_r <= (idx_r == IDX_PEN);
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    dout_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef SORT_STREAM_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating count of dropped frames
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

    assign dout.dout_valid = dout_valid_r;
    assign dout.dout_data  = dout_data_r;
    assign dout.dout_idx   = idx_r;
    assign dout.dout_last  = dout_last_r;
    assign full            = loaded_s[0] && loaded_s[1];
    assign ovf             = ovf_r;

endmodule

// File: tb/tb_sort_result_streamer.sv
// Self-checking bench: queue-based frame model checked every cycle, plus directed corner sequences.
module tb_sort_result_streamer;
    import sort_pkg::*;

    localparam int N = SORT_N;

    typedef struct {
        logic [7:0] data;
        logic [4:0] idx;
        logic       last;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              vld_in;
    logic [N*8-1:0]    din;
    logic              full;
    logic              ovf;
`ifdef SORT_STREAM_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    sort_result_streamer_if strm ();

    sort_result_streamer dut (
        .clk    (clk),
        .rst    (rst),
        .vld_in (vld_in),
        .din    (din),
        .dout   (strm),
        .full   (full),
        .ovf    (ovf)
`ifdef SORT_STREAM_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: queue of loaded frames, head is the one being streamed
    logic [N*8-1:0] m_q[$];
    bit             m_valid;
    int             m_idx;
    bit             m_ovf;
    bit             m_rst;
    int             m_drop;

    logic [13:0]    beats[$];
    int             beat_cyc[$];
    exp_t           tbl[N];
    logic [N*8-1:0] f1_w, faa_w, f55_w, f3_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        bit hs, lst, acc;
        int pre;
        m_rst = 1'b0;
        if (rst) begin
            m_q.delete();
            m_valid = 1'b0;
            m_idx = 0;
            m_ovf = 1'b0;
            m_drop = 0;
            m_rst = 1'b1;
            return;
        end
        hs  = m_valid && strm.dout_ready;
        lst = hs && (m_idx == N - 1);
        pre = m_q.size();
        acc = vld_in && ((pre < 2) || lst);
        m_ovf = vld_in && !acc;
        if (m_ovf && (m_drop < 65535)) m_drop++;
        if (lst) begin
            void'(m_q.pop_front());
            m_idx = 0;
            m_valid = (pre == 2);
        end else if (hs) begin
            m_idx++;
        end else if (!m_valid && (pre > 0)) begin
            m_valid = 1'b1;
            m_idx = 0;
        end
        if (acc) m_q.push_back(din);
    endtask

    task automatic compare();
        logic [N*8-1:0] head;
        check("dout_valid", strm.dout_valid, m_valid);
        if (m_valid) begin
            head = m_q[0];
            check("dout_data", strm.dout_data, head[m_idx*8 +: 8]);
            check("dout_idx", strm.dout_idx, m_idx);
            check("dout_last", strm.dout_last, (m_idx == N - 1));
        end else if (m_rst) begin
            check("rst_data", strm.dout_data, 0);
            check("rst_idx", strm.dout_idx, 0);
            check("rst_last", strm.dout_last, 0);
        end
        check("full", full, (m_q.size() == 2));
        check("ovf", ovf, m_ovf);
`ifdef SORT_STREAM_DROP_CNT_EN
        check("drop_cnt", drop_cnt, m_drop);
`endif
    endtask

    task automatic tick();
        if (strm.dout_valid && strm.dout_ready) begin
            beats.push_back({strm.dout_last, strm.dout_idx, strm.dout_data});
            beat_cyc.push_back(cyc);
        end
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        compare();
    endtask

    task automatic pulse(input logic [N*8-1:0] frame);
        din = frame;
        vld_in = 1'b1;
        tick();
        vld_in = 1'b0;
    endtask

    task automatic drain(input int mode, input int budget);
        for (int k = 0; k < budget; k++) begin
            strm.dout_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
            tick();
            if (!m_valid && (m_q.size() == 0)) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL drain_timeout after %0d cycles", budget);
    endtask

    task automatic check_frame_beats(input int start);
        logic [13:0] b;
        for (int i = 0; i < N; i++) begin
            if (start + i < beats.size()) begin
                b = beats[start + i];
                check("tbl_data", b[7:0], tbl[i].data);
                check("tbl_idx", b[12:8], tbl[i].idx);
                check("tbl_last", b[13], tbl[i].last);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int f1v[N] = '{0, 1, 2, 2, 3, 4, 4, 4, 4, 5, 7, 8, 8, 9, 10, 11,
                   13, 15, 16, 16, 17, 19, 20, 21, 23, 25, 27, 29, 30, 31, 32, 32};

    initial begin
        rst = 1'b1;
        vld_in = 1'b0;
        din = '0;
        strm.dout_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            f1_w[i*8 +: 8]  = 8'(f1v[i]);
            faa_w[i*8 +: 8] = 8'hAA;
            f55_w[i*8 +: 8] = 8'h55;
            f3_w[i*8 +: 8]  = 8'(i * 7 + 3);
            tbl[i].data = 8'(f1v[i]);
            tbl[i].idx  = 5'(i);
            tbl[i].last = (i == N - 1);
        end

        // 1: single frame, ready=1, latency of two edges
        do_reset();
        check("reset_full", full, 0);
        strm.dout_ready = 1'b1;
        beats.delete();
        pulse(f1_w);
        check("lat_capture_valid", strm.dout_valid, 0);
        tick();
        check("lat_present_valid", strm.dout_valid, 1);
        check("lat_present_data", strm.dout_data, 0);
        drain(0, 100);
        check("t1_beats", beats.size(), N);
        check_frame_beats(0);
        check("t1_consecutive", beat_cyc[N-1] - beat_cyc[0], N - 1);

        // 2: same frame under 1,0,0,1 backpressure
        beats.delete();
        pulse(f1_w);
        drain(1, 300);
        check("t2_beats", beats.size(), N);
        check_frame_beats(0);

        // 3: two frames five cycles apart, no bubble between them
        strm.dout_ready = 1'b1;
        beats.delete();
        beat_cyc.delete();
        pulse(f1_w);
        for (int i = 0; i < 4; i++) tick();
        pulse(faa_w);
        drain(0, 200);
        check("t3_beats", beats.size(), 2 * N);
        check_frame_beats(0);
        if (beat_cyc.size() == 2 * N)
            check("t3_no_bubble", beat_cyc[2*N-1] - beat_cyc[0], 2 * N - 1);

        // 4: overflow under full backpressure
        do_reset();
        strm.dout_ready = 1'b0;
        beats.delete();
        pulse(f1_w);
        tick();
        pulse(faa_w);
        check("t4_full", full, 1);
        tick();
        pulse(f55_w);
        check("t4_ovf_set", ovf, 1);
        tick();
        check("t4_ovf_clear", ovf, 0);
`ifdef SORT_STREAM_DROP_CNT_EN
        check("t4_drop_cnt", drop_cnt, 1);
`endif
        drain(0, 200);
        check("t4_beats", beats.size(), 2 * N);
        check_frame_beats(0);
        for (int i = 0; i < beats.size(); i++) begin
            if (beats[i][7:0] == 8'h55) check("t4_dropped_leak", beats[i][7:0], 0);
        end

        // 5: new frame on the idx-31 handshake with both buffers loaded
        strm.dout_ready = 1'b1;
        beats.delete();
        pulse(f1_w);
        tick();
        pulse(faa_w);
        for (int k = 0; k < 60; k++) begin
            if (strm.dout_valid && (strm.dout_idx == 5'd31)) break;
            tick();
        end
        check("t5_full_before", full, 1);
        pulse(f3_w);
        check("t5_no_ovf", ovf, 0);
        check("t5_full_after", full, 1);
        drain(0, 200);
        check("t5_beats", beats.size(), 3 * N);
        check_frame_beats(0);

        // 6: reset in mid-stream at idx 10
        beats.delete();
        pulse(f1_w);
        for (int k = 0; k < 40; k++) begin
            if (strm.dout_valid && (strm.dout_idx == 5'd10)) break;
            tick();
        end
        check("t6_at_idx10", strm.dout_idx, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid", strm.dout_valid, 0);
        check("t6_data", strm.dout_data, 0);
        check("t6_idx", strm.dout_idx, 0);
        check("t6_last", strm.dout_last, 0);
        check("t6_full", full, 0);
        check("t6_ovf", ovf, 0);
        beats.delete();
        pulse(f1_w);
        drain(0, 100);
        check("t6_beats", beats.size(), N);
        check_frame_beats(0);

        // 7: randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            vld_in = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < N; i++) din[i*8 +: 8] = 8'($urandom);
            strm.dout_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1'b0;
        vld_in = 1'b0;
        drain(0, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
